// File: rtl/maxpool_layer.sv
// maxpool_layer: 2x2 / stride-2 max pooling over a captured square frame.
// A frame is latched on the input handshake. One window is reduced per clock,
// and the pooled frame is held on the output handshake until it is accepted.
module maxpool_layer #(
    parameter  int INPUT_SIZE  = 4,
    parameter  int PX_SIZE     = 8,
    localparam int OUTPUT_SIZE = INPUT_SIZE / 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PX_SIZE-1:0] img_in  [INPUT_SIZE][INPUT_SIZE],
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PX_SIZE-1:0] img_out [OUTPUT_SIZE][OUTPUT_SIZE]
);

    // The window counters need at least one bit, even when OUTPUT_SIZE is 1.
    localparam int CW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(OUTPUT_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POOL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      r_q, r_d;
    logic [CW-1:0]      c_q, c_d;
    logic [PX_SIZE-1:0] frame_q   [INPUT_SIZE][INPUT_SIZE];
    logic [PX_SIZE-1:0] frame_d   [INPUT_SIZE][INPUT_SIZE];
    logic [PX_SIZE-1:0] img_out_q [OUTPUT_SIZE][OUTPUT_SIZE];
    logic [PX_SIZE-1:0] img_out_d [OUTPUT_SIZE][OUTPUT_SIZE];
    logic [PX_SIZE-1:0] win_max   [OUTPUT_SIZE][OUTPUT_SIZE];

    // Pixels are two's complement, so a set MSB must lose to any non-negative value.
    function automatic logic [PX_SIZE-1:0] smax(input logic [PX_SIZE-1:0] a,
                                               input logic [PX_SIZE-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Every window max is computed from constant indices. The POOL state then
    // picks one window by counter, so there is no variable-width index arithmetic.
    // With an odd edge length, the last row and column are never referenced.
    genvar gi, gj;
    generate
        for (gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_row
            for (gj = 0; gj < OUTPUT_SIZE; gj++) begin : g_col
                assign win_max[gi][gj] =
                    smax(smax(frame_q[2*gi][2*gj],   frame_q[2*gi][2*gj+1]),
                         smax(frame_q[2*gi+1][2*gj], frame_q[2*gi+1][2*gj+1]));
            end
        end
    endgenerate

    // Next-state logic: capture in IDLE, one window per cycle in POOL, hold in DONE.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        frame_d   = frame_q;
        img_out_d = img_out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    frame_d = img_in;
                    r_d     = '0;
                    c_d     = '0;
                    state_d = POOL;
                end
            end
            POOL: begin
                img_out_d[r_q][c_q] = win_max[r_q][c_q];
                if (c_q == LAST_IDX) begin
                    c_d = '0;
                    if (r_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        r_d = r_q + CW'(1);
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, frame buffer and result registers. The reset is asynchronous,
    // so any frame in flight is dropped and the output is cleared at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                for (int j = 0; j < INPUT_SIZE; j++) begin
                    frame_q[i][j] <= '0;
                end
            end
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                for (int j = 0; j < OUTPUT_SIZE; j++) begin
                    img_out_q[i][j] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            frame_q   <= frame_d;
            img_out_q <= img_out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign img_out   = img_out_q;

endmodule

// File: tb/tb_maxpool_layer.sv
// Directed testbench for maxpool_layer. It drives two instances: a 4x4 frame
// and an odd 5x5 frame. Inputs are driven on the falling edge and outputs are
// sampled there as well.
module tb_maxpool_layer;

    logic clk;
    logic rst_n;

    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0] img4     [4][4];
    logic [7:0] img_out4 [2][2];
    logic [7:0] exp4     [2][2];

    logic       in_valid5, in_ready5, out_valid5, out_ready5;
    logic [7:0] img5     [5][5];
    logic [7:0] img_out5 [2][2];

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int t;
    int seen;

    maxpool_layer #(.INPUT_SIZE(4), .PX_SIZE(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .img_in    (img4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .img_out   (img_out4)
    );

    maxpool_layer #(.INPUT_SIZE(5), .PX_SIZE(8)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .img_in    (img5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .img_out   (img_out5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_out4(input string tag);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                check($sformatf("%s[%0d][%0d]", tag, i, j), 32'(img_out4[i][j]), 32'(exp4[i][j]));
            end
        end
    endtask

    task automatic set_exp4(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        exp4[0][0] = a; exp4[0][1] = b; exp4[1][0] = c; exp4[1][1] = d;
    endtask

    // kind 0: 4x+y ; kind 1: 15-(4x+y) ; kind 2: 0xF0+4x+y (all negative)
    task automatic set_img4(input int kind);
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                case (kind)
                    0:       img4[x][y] = 8'(4 * x + y);
                    1:       img4[x][y] = 8'(15 - (4 * x + y));
                    default: img4[x][y] = 8'(8'hF0 + 4 * x + y);
                endcase
            end
        end
    endtask

    task automatic wait_valid4(output int l);
        l = 0;
        while (out_valid4 !== 1'b1 && l < 50) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        in_valid5  = 1'b0;
        out_ready5 = 1'b1;
        set_img4(0);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                img5[x][y] = 8'h00;
        set_exp4(8'h00, 8'h00, 8'h00, 8'h00);

        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready4), 32'd1);
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check_out4("rst_img_out");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready4), 32'd1);

        // Frame A: 4x+y -> [[5,7],[13,15]]
        set_img4(0);
        set_exp4(8'd5, 8'd7, 8'd13, 8'd15);
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        check("A_busy", 32'(in_ready4), 32'd0);
        wait_valid4(lat);
        check("A_latency", 32'(lat), 32'd4);
        check_out4("A_out");
        @(negedge clk);
        check("A_valid_one_cycle", 32'(out_valid4), 32'd0);
        check("A_back_idle", 32'(in_ready4), 32'd1);

        // Signed comparison windows
        img4[0][0] = 8'h80; img4[0][1] = 8'h81; img4[1][0] = 8'hFF; img4[1][1] = 8'h01;
        img4[0][2] = 8'h80; img4[0][3] = 8'h90; img4[1][2] = 8'hF0; img4[1][3] = 8'hFE;
        img4[2][0] = 8'h10; img4[2][1] = 8'h7F; img4[3][0] = 8'h00; img4[3][1] = 8'h20;
        img4[2][2] = 8'hFF; img4[2][3] = 8'h00; img4[3][2] = 8'h80; img4[3][3] = 8'hFF;
        set_exp4(8'h01, 8'hFE, 8'h7F, 8'h00);
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        wait_valid4(lat);
        check("S_latency", 32'(lat), 32'd4);
        check_out4("S_out");
        @(negedge clk);

        // Backpressure: frame B held while frame C is offered
        set_img4(1);
        set_exp4(8'd15, 8'd13, 8'd7, 8'd5);
        out_ready4 = 1'b0;
        in_valid4  = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        wait_valid4(lat);
        check("B_latency", 32'(lat), 32'd4);
        check_out4("B_out");
        set_img4(2);
        in_valid4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("BP_valid_%0d", i), 32'(out_valid4), 32'd1);
            check($sformatf("BP_in_ready_%0d", i), 32'(in_ready4), 32'd0);
            check_out4($sformatf("BP_hold_%0d", i));
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        check("BP_release_in_ready", 32'(in_ready4), 32'd1);
        check("BP_release_valid", 32'(out_valid4), 32'd0);
        @(negedge clk);
        check("C_captured", 32'(in_ready4), 32'd0);
        in_valid4 = 1'b0;
        set_exp4(8'hF5, 8'hF7, 8'hFD, 8'hFF);
        wait_valid4(lat);
        check("C_latency", 32'(lat), 32'd4);
        check_out4("C_out");
        @(negedge clk);

        // Reset in the middle of POOL
        set_img4(0);
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        check("R_partial_write", 32'(img_out4[0][0]), 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        set_exp4(8'h00, 8'h00, 8'h00, 8'h00);
        check("R_out_valid", 32'(out_valid4), 32'd0);
        check_out4("R_cleared");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("R_in_ready", 32'(in_ready4), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid4 === 1'b1) seen++;
        end
        check("R_no_partial_result", 32'(seen), 32'd0);
        set_img4(0);
        set_exp4(8'd5, 8'd7, 8'd13, 8'd15);
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        wait_valid4(lat);
        check("R2_latency", 32'(lat), 32'd4);
        check_out4("R2_out");
        @(negedge clk);

        // Odd edge length: row 4 and column 4 must be ignored
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                img5[x][y] = (x == 4 || y == 4) ? 8'h7F : 8'h01;
        in_valid5 = 1'b1;
        @(negedge clk);
        in_valid5 = 1'b0;
        check("O_busy", 32'(in_ready5), 32'd0);
        lat = 0;
        while (out_valid5 !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("O_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                check($sformatf("O_out[%0d][%0d]", i, j), 32'(img_out5[i][j]), 32'h01);
        @(negedge clk);
        check("O_valid_one_cycle", 32'(out_valid5), 32'd0);

        // Back-to-back frames with in_valid held high
        set_img4(1);
        set_exp4(8'd15, 8'd13, 8'd7, 8'd5);
        out_ready4 = 1'b1;
        in_valid4  = 1'b1;
        check("BB_ready_before", 32'(in_ready4), 32'd1);
        @(negedge clk);
        set_img4(2);
        check("BB_first_capture", 32'(in_ready4), 32'd0);
        t    = 0;
        seen = 0;
        while (in_ready4 !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
            if (out_valid4 === 1'b1) begin
                seen++;
                check_out4("BB_E_out");
            end
        end
        check("BB_gap", 32'(t + 1), 32'd6);
        check("BB_E_valid_cycles", 32'(seen), 32'd1);
        @(negedge clk);
        check("BB_second_capture", 32'(in_ready4), 32'd0);
        in_valid4 = 1'b0;
        set_exp4(8'hF5, 8'hF7, 8'hFD, 8'hFF);
        wait_valid4(lat);
        check("BB_F_latency", 32'(lat), 32'd4);
        check_out4("BB_F_out");
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/maxpool_layer.md
# maxpool_layer

2x2, stride-2 max-pooling layer that consumes a full ReLU-rectified frame and produces a frame with half the width and height. It sits directly downstream of the rectifier layer in the CNN datapath, and uses the same parallel square-frame pixel layout on both sides. A frame is captured through a valid/ready handshake and reduced one window per clock. The pooled frame is then held under a second valid/ready handshake until the next stage accepts it.

## Interface
- INPUT_SIZE, 4, input frame edge length (square). Any value ≥ 2; odd values allowed.
- PX_SIZE, 8, bits per pixel, two's complement.
- OUTPUT_SIZE, INPUT_SIZE/2 (integer floor), derived; output frame edge length. Not to be overridden.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  img_in holds a frame to capture.
- in_ready  output  1  block can accept a frame.
- img_in  input  [INPUT_SIZE][INPUT_SIZE][PX_SIZE]  input frame, indexed [row][col].
- out_valid  output  1  img_out holds a complete pooled frame.
- out_ready  input  1  downstream accepts img_out.
- img_out  output  [OUTPUT_SIZE][OUTPUT_SIZE][PX_SIZE]  pooled frame, registered.

## Operation
- FSM with three states: IDLE, POOL and DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, register img_in into an internal frame buffer.
  - Clear the window counters: row r=0, col c=0.
  - Go to POOL.
- POOL:
  - Each cycle, compute the max of frame[2r][2c], frame[2r][2c+1], frame[2r+1][2c] and frame[2r+1][2c+1], using a **signed** comparison.
  - Write the result to img_out[r][c].
  - Advance c; when c wraps at OUTPUT_SIZE-1, reset c to 0 and advance r.
  - After the write at (OUTPUT_SIZE-1, OUTPUT_SIZE-1), go to DONE.
- DONE:
  - out_valid=1; img_out is held stable.
  - On out_ready=1, go to IDLE.
- Odd INPUT_SIZE: the last row and last column are never read and are dropped.
- Ties between window values have no observable effect; any equal maximum is correct.
- in_valid is ignored in POOL and DONE. The frame buffer changes only on a capture.
- Values with the MSB set are negative. They never win against a non-negative value in the same window.

## Timing
- Reset (rst_n=0, takes effect immediately without waiting for clk):
  - State goes to IDLE; counters, frame buffer and every img_out element go to 0.
  - out_valid=0; in_ready=1 as soon as rst_n is released (combinational from state).
- in_ready = (state==IDLE), combinational. out_valid = (state==DONE), registered through the state.
- Capture at rising edge k, then OUTPUT_SIZE² POOL cycles.
  - The first window is written at edge k+1.
  - The last window is written at edge k+OUTPUT_SIZE², and the state enters DONE on that same edge.
  - out_valid is high from edge k+OUTPUT_SIZE² onward. For INPUT_SIZE=4 that is 4 cycles after capture.
- During POOL, img_out is partially updated and must not be sampled. Only img_out while out_valid=1 is defined.
- In DONE, out_ready=1 at edge m sends the state to IDLE. in_ready rises after edge m, so the earliest next capture is edge m+1. A frame presented in the same cycle as the DONE→IDLE transition is not captured.
- Throughput: one frame per OUTPUT_SIZE²+2 cycles with no backpressure.
- Reset asserted during POOL or DONE abandons the frame. No partial result is presented after reset.

## Test plan
- INPUT_SIZE=4, PX_SIZE=8, img_in[x][y]=4x+y, out_ready=1:
  - img_out=[[5,7],[13,15]].
  - out_valid rises 4 cycles after the capture edge and stays high exactly 1 cycle.
- Signed compare: one window {0x80,0x81,0xFF,0x01} -> 0x01. An all-negative window {0x80,0x90,0xF0,0xFE} -> 0xFE.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid rises, and drive a different img_in with in_valid=1 throughout.
  - img_out stays unchanged and in_ready stays 0; the new frame is not captured.
  - Raise out_ready: one cycle later in_ready=1 and the new frame is captured.
- Reset mid-POOL: assert rst_n=0 two cycles after capture.
  - out_valid=0 and img_out all 0 immediately; in_ready=1 after release.
  - A subsequent frame produces the correct result.
- Odd size INPUT_SIZE=5:
  - Frame all 0x01 except row 4 and column 4 = 0x7F -> img_out all 0x01, 2x2.
  - out_valid 4 cycles after capture.
- Back-to-back: two frames, in_valid held high, out_ready=1.
  - Second capture occurs exactly OUTPUT_SIZE²+2 cycles after the first.
  - Both outputs are correct.
